// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage: FIFO-buffered words emitted MSB-first on ser_d/ser_en.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned GAP   = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_d,
  output logic         ser_en,
  output logic         frame_done,
  output logic         busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int unsigned FW = N + 1;
`else
  localparam int unsigned FW = N;
`endif
  localparam int unsigned CW = $clog2(FW);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned QW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] BitLoad = CW'(FW - 1);
  localparam logic [3:0]    GapLoad = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);
  localparam logic [QW-1:0] QDepth  = QW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QW-1:0]   count_q, count_d;
  logic [FW-1:0]   shift_q, shift_d, load_val;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic            ser_d_q, ser_d_d, ser_en_q, ser_en_d, frame_done_q, frame_done_d;
  logic            push, pop, fifo_ne, last_bit;
  logic [N-1:0]    head;

  assign in_ready = (count_q < QDepth);
  assign push     = in_valid && in_ready;
  assign fifo_ne  = (count_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign last_bit = (bit_cnt_q == '0);

`ifdef PISO_SERIALIZER_PARITY_EN
  assign load_val = {head, ^head};
`else
  assign load_val = head;
`endif

  // FIFO bookkeeping; in_ready uses registered count so a same-edge pop never frees a slot
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (fifo_ne) state_d = StShift;
      StShift: begin
        if (last_bit) begin
          if (GAP > 0)      state_d = StGap;
          else if (fifo_ne) state_d = StShift;
          else              state_d = StIdle;
        end
      end
      StGap:   if (gap_cnt_q == '0) state_d = fifo_ne ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop          = 1'b0;
    ser_en_d     = 1'b0;
    ser_d_d      = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      StIdle:  pop = fifo_ne;
      StShift: begin
        ser_en_d = 1'b1;
        ser_d_d  = shift_q[FW-1];
        if (last_bit) begin
          frame_done_d = 1'b1;
          pop          = (GAP == 0) && fifo_ne;
        end
      end
      StGap:   pop = (gap_cnt_q == '0) && fifo_ne;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (pop) begin
      shift_d   = load_val;
      bit_cnt_d = BitLoad;
    end else if (state_q == StShift && !last_bit) begin
      shift_d   = {shift_q[FW-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q - 1'b1;
    end
    if (state_q == StShift && last_bit) gap_cnt_d = GapLoad;
    else if (state_q == StGap && gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      ser_d_q      <= 1'b0;
      ser_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      ser_d_q      <= ser_d_d;
      ser_en_q     <= ser_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ser_d      = ser_d_q;
  assign ser_en     = ser_en_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != StIdle) || fifo_ne;

endmodule
